split_bytes: RTL and testbench

Bitstream reader for the JPEG decode path; the inverse of the encoder's byte concatenator. Accepts fixed 32-bit words of a packed, MSB-first variable-length code stream and presents a left-aligned 24-bit lookahead window. The downstream Huffman/VLC decoder consumes 0–24 bits per cycle from that window. Sits between the 32-bit stream source (memory/DMA reader) and the entropy decoder, and signals end of image once the final word has been fully consumed.

---
 rtl/split_bytes_pkg.sv | 13 +
 rtl/split_bytes_if.sv | 31 +++
 rtl/split_bytes.sv | 75 +++++++
 tb/tb_split_bytes.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/split_bytes_pkg.sv
// Shared JPEG decode-path definitions.
// Holds the fixed datapath widths and the bitstream reader state encoding.
package jpeg_pkg;
    localparam int WORD_W = 32;   // input stream word
    localparam int WIN_W  = 24;   // lookahead window presented to the VLC decoder
    localparam int BUF_W  = 64;   // internal left-aligned bit buffer

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } split_state_t;
endpackage

// File: rtl/split_bytes_if.sv
// Stream/window bus between the word source, split_bytes and the entropy decoder.
//   in_bin/in_valid/in_last/in_ready : 32-bit word input handshake
//   out_bin/out_len/out_valid        : left-aligned 24-bit lookahead window
//   rd_en/rd_len                     : consumer bit read request
//   out_eoi/out_err                  : end-of-image pulse, sticky read error
// master = stream source + consumer side, slave = split_bytes.
interface split_bytes_if;
    import jpeg_pkg::*;

    logic [WORD_W-1:0] in_bin;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [WIN_W-1:0]  out_bin;
    logic [6:0]        out_len;
    logic              out_valid;
    logic              rd_en;
    logic [4:0]        rd_len;
    logic              out_eoi;
    logic              out_err;

    modport master (
        output in_bin, in_valid, in_last, rd_en, rd_len,
        input  in_ready, out_bin, out_len, out_valid, out_eoi, out_err
    );

    modport slave (
        input  in_bin, in_valid, in_last, rd_en, rd_len,
        output in_ready, out_bin, out_len, out_valid, out_eoi, out_err
    );
endinterface

// File: rtl/split_bytes.sv
// split_bytes: MSB-first bitstream reader for the JPEG decoder.
// Accepts 32-bit packed code words into a 64-bit left-aligned buffer and
// presents the top 24 bits as a lookahead window; the consumer removes
// 0..24 bits per cycle. After the word flagged in_last, the remaining bits
// are drained and out_eoi pulses once the buffer is empty.
// Ports:
//   clk  : clock, rising edge
//   nrst : asynchronous active-low reset
//   bus  : split_bytes_if.slave (word input, window output, read request)
module split_bytes
    import jpeg_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    split_bytes_if.slave bus
);
    split_state_t      state_q;
    logic [BUF_W-1:0]  buff_q, buff_d;
    logic [6:0]        len_q, len_d;
    logic              err_q;

    logic [6:0]        c;        // bits consumed this cycle
    logic [6:0]        len_s;    // length after consume, before append
    logic [6:0]        rd_len_w;
    logic              valid, ready, accept, illegal, honour;

    // Handshake outputs depend on registers only: no rd_en -> in_ready path.
    assign ready    = (state_q == ACTIVE) && (len_q <= 7'd32);
    assign valid    = (len_q >= 7'd24) || ((state_q == DRAIN) && (len_q != 7'd0));
    assign accept   = bus.in_valid && ready;
    assign rd_len_w = {2'b00, bus.rd_len};

    // An over-long request is an error even without a usable window; an
    // over-length request only counts while the window is valid.
    assign illegal  = bus.rd_en && ((rd_len_w > 7'd24) || (valid && (rd_len_w > len_q)));
    assign honour   = bus.rd_en && valid && !illegal;

    always_comb begin
        c      = honour ? rd_len_w : 7'd0;
        len_s  = len_q - c;
        buff_d = buff_q << c;
        len_d  = len_s;
        // accept implies len_q <= 32, so len_s + 32 always fits in 64 bits
        if (accept) begin
            buff_d = buff_d | ({bus.in_bin, {WORD_W{1'b0}}} >> len_s);
            len_d  = len_s + 7'd32;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ACTIVE;
            buff_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            buff_q <= buff_d;
            len_q  <= len_d;
            if (illegal) err_q <= 1'b1;
            case (state_q)
                ACTIVE:  if (accept && bus.in_last) state_q <= DRAIN;
                DRAIN:   if (len_d == 7'd0)         state_q <= DONE;
                DONE:                               state_q <= ACTIVE;
                default:                            state_q <= ACTIVE;
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out_bin   = buff_q[BUF_W-1 -: WIN_W];
    assign bus.out_len   = len_q;
    assign bus.out_eoi   = (state_q == DONE);
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_split_bytes.sv
// Self-checking bench for split_bytes: bit-queue scoreboard model plus a
// table of directed vectors and hand-written corner sequences.
module tb_split_bytes;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    split_bytes_if bus();
    split_bytes dut (.clk(clk), .nrst(nrst), .bus(bus));

    // Scoreboard: stream bits pushed on accept, popped on honoured reads.
    bit mq[$];
    int mst = 0;          // 0 ACTIVE, 1 DRAIN, 2 DONE
    bit merr = 0;

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic        l;
        logic        re;
        logic [4:0]  rl;
        logic [23:0] exp_bin;
        logic [6:0]  exp_len;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return (mst == 0) && (mq.size() <= 32);
    endfunction

    function automatic bit m_valid();
        return (mq.size() >= 24) || ((mst == 1) && (mq.size() != 0));
    endfunction

    function automatic logic [23:0] m_win();
        logic [23:0] r = '0;
        for (int i = 0; i < 24; i++)
            if (i < mq.size()) r[23-i] = mq[i];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        mst = 0;
        merr = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] w, input logic l,
                              input logic re, input logic [4:0] rl);
        bit acc, ill, ok, vld;
        int old;
        vld = m_valid();
        acc = v && m_ready();
        ill = re && ((rl > 24) || (vld && (int'(rl) > mq.size())));
        ok  = re && vld && !ill;
        if (ill) merr = 1;
        if (ok) for (int i = 0; i < rl; i++) void'(mq.pop_front());
        if (acc) for (int i = 31; i >= 0; i--) mq.push_back(w[i]);
        old = mst;
        if (old == 2) mst = 0;
        else if (old == 0 && acc && l) mst = 1;
        else if (old == 1 && mq.size() == 0) mst = 2;
    endtask

    task automatic cmp_model();
        chk("in_ready",  bus.in_ready,  m_ready());
        chk("out_valid", bus.out_valid, m_valid());
        chk("out_bin",   bus.out_bin,   m_win());
        chk("out_len",   bus.out_len,   mq.size());
        chk("out_eoi",   bus.out_eoi,   mst == 2);
        chk("out_err",   bus.out_err,   merr);
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic l,
                        input logic re, input logic [4:0] rl);
        bus.in_valid = v; bus.in_bin = w; bus.in_last = l;
        bus.rd_en = re; bus.rd_len = rl;
        model_step(v, w, l, re, rl);
        @(posedge clk); #1;
        bus.in_valid = 0; bus.in_last = 0; bus.rd_en = 0; bus.rd_len = 0;
        cmp_model();
    endtask

    task automatic do_reset();
        nrst = 0;
        #3;
        model_reset();
        @(negedge clk); nrst = 1;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.in_ready,  1'b1);
        chk({tag, "_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_bin"},   bus.out_bin,   24'h0);
        chk({tag, "_len"},   bus.out_len,   7'd0);
        chk({tag, "_eoi"},   bus.out_eoi,   1'b0);
        chk({tag, "_err"},   bus.out_err,   1'b0);
    endtask

    logic [31:0] wa, wb;

    initial begin
        bus.in_valid = 0; bus.in_bin = '0; bus.in_last = 0;
        bus.rd_en = 0; bus.rd_len = '0;

        #12;
        chk_reset_vals("rst");
        @(negedge clk); nrst = 1;
        @(posedge clk); #1;

        // Directed table: expectations hand-derived from the stream contents.
        tbl[0] = '{1, 32'hA5A5A5A5, 0, 0, 5'd0,  24'hA5A5A5, 7'd32};
        tbl[1] = '{0, 32'h0,        0, 1, 5'd4,  24'h5A5A5A, 7'd28};
        tbl[2] = '{0, 32'h0,        0, 1, 5'd24, 24'h500000, 7'd4};
        tbl[3] = '{0, 32'h0,        0, 1, 5'd4,  24'h500000, 7'd4};   // not valid: ignored
        tbl[4] = '{1, 32'h12345678, 0, 0, 5'd0,  24'h512345, 7'd36};
        tbl[5] = '{1, 32'h9ABCDEF0, 0, 1, 5'd24, 24'h678000, 7'd12};  // not ready: dropped
        tbl[6] = '{1, 32'h9ABCDEF0, 0, 0, 5'd0,  24'h6789AB, 7'd44};
        tbl[7] = '{1, 32'h11111111, 0, 1, 5'd24, 24'hCDEF00, 7'd20};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].w, tbl[i].l, tbl[i].re, tbl[i].rl);
            chk("tbl_bin", bus.out_bin, tbl[i].exp_bin);
            chk("tbl_len", bus.out_len, tbl[i].exp_len);
        end

        // Back-to-back words with a 24-bit read in the same cycle.
        do_reset();
        step(1, 32'h12345678, 0, 0, 0);
        chk("b2b_win0", bus.out_bin, 24'h123456);
        step(1, 32'h9ABCDEF0, 0, 1, 24);
        chk("b2b_win1", bus.out_bin, 24'h789ABC);
        chk("b2b_len1", bus.out_len, 7'd40);
        chk("b2b_rdy1", bus.in_ready, 1'b0);

        // Sustained random traffic against the bit-queue model.
        for (int i = 0; i < 60; i++) begin
            int n = mq.size();
            int mx = (n < 24) ? n : 24;
            step(1, $urandom, 0, m_valid(), 5'($urandom_range(0, mx)));
        end

        // Same-cycle consume and append with buff_len = 32.
        do_reset();
        wa = 32'hC3A5_0F96; wb = 32'h5E1D_7B24;
        step(1, wa, 0, 0, 0);
        step(1, wb, 0, 1, 7);
        chk("sc_len", bus.out_len, 7'd57);
        chk("sc_bin", bus.out_bin, wa[24:1]);
        step(0, 0, 0, 1, 24);
        chk("sc_join", bus.out_bin, {wa[0], wb[31:9]});

        // Final word, drain, over-read error, end-of-image pulse.
        do_reset();
        step(1, 32'hABCDEFFF, 1, 0, 0);
        chk("last_rdy", bus.in_ready, 1'b0);
        step(0, 0, 0, 1, 20);
        chk("dr_bin12", bus.out_bin, 24'hFFF000);
        step(0, 0, 0, 1, 20);
        chk("err_set", bus.out_err, 1'b1);
        chk("err_len", bus.out_len, 7'd12);
        step(0, 0, 0, 1, 2);
        chk("dr_bin10", bus.out_bin, 24'hFFC000);
        chk("dr_vld10", bus.out_valid, 1'b1);
        chk("err_stky", bus.out_err, 1'b1);
        step(0, 0, 0, 1, 10);
        chk("eoi_hi", bus.out_eoi, 1'b1);
        chk("eoi_vld", bus.out_valid, 1'b0);
        step(0, 0, 0, 0, 0);
        chk("eoi_lo", bus.out_eoi, 1'b0);
        chk("back_rdy", bus.in_ready, 1'b1);

        // rd_len beyond the window width.
        do_reset();
        step(1, 32'h0F0F0F0F, 0, 0, 0);
        step(0, 0, 0, 1, 25);
        chk("err25", bus.out_err, 1'b1);
        chk("err25_len", bus.out_len, 7'd32);

        // Asynchronous reset mid-stream with 40 bits buffered.
        do_reset();
        step(1, 32'hDEADBEEF, 0, 0, 0);
        step(1, 32'hCAFEF00D, 0, 1, 24);
        chk("mid_len", bus.out_len, 7'd40);
        #3 nrst = 0;
        #1 chk_reset_vals("arst");
        model_reset();
        #2 nrst = 1;
        @(posedge clk); #1;
        cmp_model();
        step(1, 32'h87654321, 0, 0, 0);
        chk("arst_first", bus.out_bin, 24'h876543);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
